spi_slave_sync: RTL and testbench

Synthesisable SPI slave that oversamples `spi_clk`, `spi_cs` and `spi_mosi` in the system clock domain and presents received words on a pulse interface. Transmit words come from a one-deep holding register with a valid/ready handshake. It generalises the existing fixed-mode bench SPI adapter with these additions:
- parametrised word width;
- all four CPOL/CPHA modes;
- multi-word frames;
- partial-word reporting;
- underrun detection.

It sits between the board SPI pins and the register/command logic.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_slave_sync.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_sync.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, FSM state encoding and edge-polarity helper.
package spi_pkg;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_e;

    typedef struct packed {
        logic sample_rise;
        logic shift_rise;
    } spi_edge_t;

    // Sample on the leading edge when CPHA=0; leading edge is rising when CPOL=0.
    function automatic spi_edge_t spi_edge_sel(input logic cpol, input logic cpha);
        spi_edge_t e;
        e.sample_rise = ~(cpol ^ cpha);
        e.shift_rise  = cpol ^ cpha;
        return e;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input with rise/fall pulses on the synchronised level.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync;
    logic              q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RST_VAL}};
            q_d  <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            q_d  <= sync[STAGES-1];
        end
    end

    assign rise_c = sync[STAGES-1] & ~q_d;
    assign fall_c = ~sync[STAGES-1] & q_d;

endmodule

// File: rtl/spi_slave_sync.sv
// Oversampling SPI slave: pulse-style receive interface, one-deep transmit holding register.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           spi_clk,
    input  logic                           spi_cs,
    input  logic                           spi_mosi,
    output logic                           spi_miso,
    input  logic [WIDTH-1:0]               tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic [WIDTH-1:0]               rx_data,
    output logic [$clog2(WIDTH+1)-1:0]     rx_bits,
    output logic                           rx_valid,
    output logic                           err_underrun,
    output logic                           busy
);

    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
    localparam spi_edge_t   EDGE     = spi_edge_sel(1'(CPOL), 1'(CPHA));
    localparam logic        HAS_CPHA = 1'(CPHA);

    logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (spi_clk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // Reset low so a CS held low across reset is not taken as a new frame.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (spi_cs),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sync <= '0;
        else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    spi_state_e       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift, tx_shift, hold;
    logic             first_shift;

    logic             sample_c, shift_c, word_done_c, tx_reload_c;
    logic [CNT_W-1:0] cnt_inc_c, cnt_after_c;
    logic [WIDTH-1:0] rx_after_c, part_mask_c;

    assign sample_c = EDGE.sample_rise ? sclk_rise_c : sclk_fall_c;
    assign shift_c  = EDGE.shift_rise  ? sclk_rise_c : sclk_fall_c;

    // Effect of this cycle's sample edge, seen before any CS-rise termination.
    always_comb begin
        cnt_inc_c   = bit_cnt + CNT_W'(1);
        word_done_c = sample_c && (cnt_inc_c == CNT_W'(WIDTH));
        rx_after_c  = rx_shift;
        cnt_after_c = bit_cnt;
        if (sample_c) begin
            rx_after_c  = {rx_shift[WIDTH-2:0], mosi_s};
            cnt_after_c = word_done_c ? '0 : cnt_inc_c;
        end
        tx_reload_c = shift_c && (bit_cnt == '0) && !(HAS_CPHA && first_shift);
        part_mask_c = ~({WIDTH{1'b1}} << cnt_after_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SPI_IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            hold         <= '0;
            first_shift  <= 1'b0;
            tx_ready     <= 1'b1;
            rx_data      <= '0;
            rx_bits      <= '0;
            rx_valid     <= 1'b0;
            err_underrun <= 1'b0;
            busy         <= 1'b0;
            spi_miso     <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            err_underrun <= 1'b0;
            spi_miso     <= (state == SPI_ACTIVE) && tx_shift[WIDTH-1];

            if (tx_valid && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end

            case (state)
                SPI_IDLE: begin
                    if (cs_fall_c) begin
                        state       <= SPI_ACTIVE;
                        busy        <= 1'b1;
                        bit_cnt     <= '0;
                        rx_shift    <= '0;
                        first_shift <= 1'b1;
                        if (!tx_ready) begin
                            tx_shift <= hold;
                            tx_ready <= 1'b1;
                        end else begin
                            tx_shift     <= '0;
                            err_underrun <= 1'b1;
                        end
                    end
                end
                SPI_ACTIVE: begin
                    bit_cnt  <= cnt_after_c;
                    rx_shift <= rx_after_c;
                    if (word_done_c) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_after_c;
                        rx_bits  <= CNT_W'(WIDTH);
                    end
                    if (cs_rise_c) begin
                        state <= SPI_IDLE;
                        busy  <= 1'b0;
                        if (cnt_after_c != '0) begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_after_c & part_mask_c;
                            rx_bits  <= cnt_after_c;
                        end
                    end else if (shift_c) begin
                        first_shift <= 1'b0;
                        if (bit_cnt != '0) begin
                            tx_shift <= tx_shift << 1;
                        end else if (tx_reload_c) begin
                            if (!tx_ready) begin
                                tx_shift <= hold;
                                tx_ready <= 1'b1;
                            end else begin
                                tx_shift     <= '0;
                                err_underrun <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= SPI_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: four instances (modes 0,1,3 at 8 bits, mode 2 at 16 bits) driven by a pin-level master.
module tb_spi_slave_sync;

    localparam int H   = 6;   // spi_clk half period in clk cycles
    localparam int CSU = 8;   // CS setup / hold around the clock burst

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  bits;
    } rx_rec_t;

    logic        clk, rst_n;
    logic        sclk [4];
    logic        cs   [4];
    logic        mosi [4];
    logic        txv  [4];
    logic [15:0] txd  [4];
    logic        win  [4];
    wire         miso [4];
    wire         txr  [4];
    wire         rxv  [4];
    wire         errv [4];
    wire         bsy  [4];
    wire  [15:0] rxd  [4];
    wire  [7:0]  rxb  [4];

    wire [7:0]  rxd0, rxd1, rxd3;
    wire [15:0] rxd2;
    wire [3:0]  rxb0, rxb1, rxb3;
    wire [4:0]  rxb2;

    assign rxd[0] = 16'(rxd0);
    assign rxd[1] = 16'(rxd1);
    assign rxd[2] = rxd2;
    assign rxd[3] = 16'(rxd3);
    assign rxb[0] = 8'(rxb0);
    assign rxb[1] = 8'(rxb1);
    assign rxb[2] = 8'(rxb2);
    assign rxb[3] = 8'(rxb3);

    spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_m0 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sclk[0]), .spi_cs(cs[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .tx_data(txd[0][7:0]), .tx_valid(txv[0]), .tx_ready(txr[0]),
        .rx_data(rxd0), .rx_bits(rxb0), .rx_valid(rxv[0]), .err_underrun(errv[0]), .busy(bsy[0]));

    spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(1), .SYNC_STAGES(2)) u_m1 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sclk[1]), .spi_cs(cs[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .tx_data(txd[1][7:0]), .tx_valid(txv[1]), .tx_ready(txr[1]),
        .rx_data(rxd1), .rx_bits(rxb1), .rx_valid(rxv[1]), .err_underrun(errv[1]), .busy(bsy[1]));

    spi_slave_sync #(.WIDTH(16), .CPOL(1), .CPHA(0), .SYNC_STAGES(2)) u_m2 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sclk[2]), .spi_cs(cs[2]), .spi_mosi(mosi[2]),
        .spi_miso(miso[2]), .tx_data(txd[2]), .tx_valid(txv[2]), .tx_ready(txr[2]),
        .rx_data(rxd2), .rx_bits(rxb2), .rx_valid(rxv[2]), .err_underrun(errv[2]), .busy(bsy[2]));

    spi_slave_sync #(.WIDTH(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_m3 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sclk[3]), .spi_cs(cs[3]), .spi_mosi(mosi[3]),
        .spi_miso(miso[3]), .tx_data(txd[3][7:0]), .tx_valid(txv[3]), .tx_ready(txr[3]),
        .rx_data(rxd3), .rx_bits(rxb3), .rx_valid(rxv[3]), .err_underrun(errv[3]), .busy(bsy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_chk  = 0;
    int      n_fail = 0;
    int      err_win [4];
    rx_rec_t rx_q [$];

    // Record every received word; count underrun pulses inside the word-start window.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rxv[k] === 1'b1) rx_q.push_back('{data: rxd[k], bits: rxb[k]});
            if (errv[k] === 1'b1 && win[k]) err_win[k]++;
        end
    end

    function automatic int wid(input int i);
        return (i == 2) ? 16 : 8;
    endfunction
    function automatic logic cpol(input int i);
        return 1'(i >= 2);
    endfunction
    function automatic logic cpha(input int i);
        return 1'((i == 1) || (i == 3));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int i, input logic [15:0] w);
        int t = 0;
        while (txr[i] !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("tx_ready wait inst%0d", i), 64'(t < 3000), 64'd1);
        txd[i] = w;
        txv[i] = 1'b1;
        @(negedge clk);
        txv[i] = 1'b0;
    endtask

    task automatic feeder(input int i, input int s, input logic [15:0] tw [3]);
        for (int k = 1; k < s; k++) load_word(i, tw[k]);
    endtask

    // Pin-level master, MSB first; mo[nbits-1] is sent first.
    task automatic frame(input int i, input int nbits, input logic [47:0] mo, output logic [47:0] mi);
        logic pol, ph;
        pol = cpol(i);
        ph  = cpha(i);
        mi  = '0;
        mosi[i] = ph ? 1'b0 : mo[nbits-1];
        win[i]  = 1'b1;
        cs[i]   = 1'b0;
        tick(CSU);
        chk($sformatf("busy in frame inst%0d", i), 64'(bsy[i]), 64'd1);
        for (int j = 0; j < nbits; j++) begin
            if (!ph) begin
                mi = {mi[46:0], miso[i]};
                sclk[i] = ~pol;
                tick(H);
                if (j == nbits - 1) win[i] = 1'b0;
                sclk[i] = pol;
                if (j < nbits - 1) mosi[i] = mo[nbits-2-j];
                tick(H);
            end else begin
                sclk[i] = ~pol;
                mosi[i] = mo[nbits-1-j];
                tick(H);
                mi = {mi[46:0], miso[i]};
                sclk[i] = pol;
                tick(H);
            end
        end
        win[i] = 1'b0;
        tick(CSU);
        cs[i] = 1'b1;
        tick(12);
    endtask

    // One frame with s words supplied through the holding register, checked against the word-level model.
    task automatic run_frame(input int i, input int nbits, input logic [47:0] mo, input int s,
                             input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        int          W, nw, exp_cnt, slot, pos;
        logic [15:0] tw [3];
        logic [15:0] word;
        logic [47:0] exp_mi, mi, ed;
        int          eb;
        W  = wid(i);
        nw = (nbits + W - 1) / W;
        tw[0] = w0; tw[1] = w1; tw[2] = w2;
        exp_mi = '0;
        for (int j = 0; j < nbits; j++) begin
            slot   = j / W;
            pos    = j % W;
            word   = (slot < s) ? tw[slot] : 16'h0;
            exp_mi = {exp_mi[46:0], word[W-1-pos]};
        end
        rx_q.delete();
        err_win[i] = 0;
        if (s >= 1) begin
            load_word(i, w0);
            chk($sformatf("tx_ready low after load inst%0d", i), 64'(txr[i]), 64'd0);
        end
        fork
            frame(i, nbits, mo, mi);
            feeder(i, s, tw);
        join
        chk($sformatf("miso stream inst%0d", i), 64'(mi), 64'(exp_mi));
        chk($sformatf("underrun count inst%0d", i), 64'(err_win[i]), 64'(nw - s));
        chk($sformatf("tx_ready after frame inst%0d", i), 64'(txr[i]), 64'd1);
        chk($sformatf("busy after frame inst%0d", i), 64'(bsy[i]), 64'd0);
        exp_cnt = nbits / W + (((nbits % W) != 0) ? 1 : 0);
        chk($sformatf("rx pulses inst%0d", i), 64'(rx_q.size()), 64'(exp_cnt));
        for (int k = 0; k < exp_cnt && k < rx_q.size(); k++) begin
            if ((k + 1) * W <= nbits) begin
                ed = (mo >> (nbits - (k + 1) * W)) & ((48'd1 << W) - 48'd1);
                eb = W;
            end else begin
                eb = nbits % W;
                ed = mo & ((48'd1 << eb) - 48'd1);
            end
            chk($sformatf("rx_data[%0d] inst%0d", k, i), 64'(rx_q[k].data), 64'(ed));
            chk($sformatf("rx_bits[%0d] inst%0d", k, i), 64'(rx_q[k].bits), 64'(eb));
        end
    endtask

    task automatic check_reset_vals(input int i);
        chk($sformatf("rst spi_miso inst%0d", i), 64'(miso[i]), 64'd0);
        chk($sformatf("rst tx_ready inst%0d", i), 64'(txr[i]), 64'd1);
        chk($sformatf("rst rx_valid inst%0d", i), 64'(rxv[i]), 64'd0);
        chk($sformatf("rst rx_data inst%0d", i), 64'(rxd[i]), 64'd0);
        chk($sformatf("rst rx_bits inst%0d", i), 64'(rxb[i]), 64'd0);
        chk($sformatf("rst err_underrun inst%0d", i), 64'(errv[i]), 64'd0);
        chk($sformatf("rst busy inst%0d", i), 64'(bsy[i]), 64'd0);
    endtask

    initial begin
        int          nb, s, nw;
        logic [47:0] mo_r;
        for (int i = 0; i < 4; i++) begin
            sclk[i] = cpol(i); cs[i] = 1'b1; mosi[i] = 1'b0;
            txv[i] = 1'b0; txd[i] = '0; win[i] = 1'b0; err_win[i] = 0;
        end
        rst_n = 1'b0;
        tick(3);
        for (int i = 0; i < 4; i++) check_reset_vals(i);
        rst_n = 1'b1;
        tick(5);

        // Mode 0 single word
        run_frame(0, 8, 48'h3C, 1, 16'hA5, 16'h0, 16'h0);
        // Mode 3, two words in one frame via handshake
        run_frame(3, 16, 48'hF00F, 2, 16'h12, 16'h34, 16'h0);
        // Mode 1, partial word 10110
        run_frame(1, 5, 48'b10110, 1, 16'hC3, 16'h0, 16'h0);
        // Holding empty at frame start
        run_frame(0, 8, 48'h5A, 0, 16'h0, 16'h0, 16'h0);
        // Mode 2, 16-bit word
        run_frame(2, 16, 48'hCAFE, 1, 16'hBEEF, 16'h0, 16'h0);

        // Reset in the middle of a frame
        rx_q.delete();
        cs[0] = 1'b0;
        tick(CSU);
        for (int j = 0; j < 3; j++) begin
            mosi[0] = 1'b1; sclk[0] = 1'b1; tick(H);
            sclk[0] = 1'b0; tick(H);
        end
        rst_n = 1'b0;
        tick(1);
        check_reset_vals(0);
        rst_n = 1'b1;
        tick(CSU);
        chk("busy after reset with cs low", 64'(bsy[0]), 64'd0);
        cs[0] = 1'b1;
        tick(12);
        chk("rx pulses aborted frame", 64'(rx_q.size()), 64'd0);
        run_frame(0, 8, 48'h81, 1, 16'h6D, 16'h0, 16'h0);

        // Random frames on every mode against the word-level model
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 3; r++) begin
                nb   = int'($urandom_range(1, 3 * wid(i)));
                nw   = (nb + wid(i) - 1) / wid(i);
                s    = int'($urandom_range(0, nw));
                mo_r = 48'({$urandom(), $urandom()});
                run_frame(i, nb, mo_r, s, 16'($urandom()), 16'($urandom()), 16'($urandom()));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
